// File: rtl/vsd_caravel_pkg.sv
// Shared constants, command codes and FSM state type
// for the vsdcaravel housekeeping SPI block.
package vsd_caravel_pkg;

    localparam logic [7:0] CMD_WSTREAM  = 8'h80;
    localparam logic [7:0] CMD_RSTREAM  = 8'h40;
    localparam logic [7:0] CMD_RWSTREAM = 8'hC0;
    localparam logic [7:0] CMD_PASSTHRU = 8'hC4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_PASS,
        ST_DONE
    } hk_state_e;

    localparam logic [7:0] A_STATUS  = 8'h00;
    localparam logic [7:0] A_MFGR_HI = 8'h01;
    localparam logic [7:0] A_MFGR_LO = 8'h02;
    localparam logic [7:0] A_PROD    = 8'h03;
    localparam logic [7:0] A_PLL_EN  = 8'h08;
    localparam logic [7:0] A_PLL_BYP = 8'h09;
    localparam logic [7:0] A_IRQ     = 8'h0A;
    localparam logic [7:0] A_EXT_RST = 8'h0B;
    localparam logic [7:0] A_TRIM0   = 8'h0D;
    localparam logic [7:0] A_TRIM1   = 8'h0E;
    localparam logic [7:0] A_TRIM2   = 8'h0F;
    localparam logic [7:0] A_TRIM3   = 8'h10;
    localparam logic [7:0] A_PLL_SRC = 8'h11;
    localparam logic [7:0] A_PLL_DIV = 8'h12;
    localparam logic [7:0] LAST_REG  = 8'h12;

    localparam logic [11:0] MFGR_ID_DEF  = 12'h456;
    localparam logic [7:0]  PROD_ID_DEF  = 8'h11;
    localparam logic [25:0] PLL_TRIM_DEF = 26'h3FFEFFF;
    localparam logic [1:0]  PLL_EN_RST   = 2'b10;
    localparam logic        PLL_BYP_RST  = 1'b1;
    localparam logic [5:0]  PLL_SRC_RST  = 6'h12;
    localparam logic [4:0]  PLL_DIV_RST  = 5'h04;

    // Stream commands: nonzero mode with a zero sub-field.
    function automatic logic is_stream(input logic [7:0] c);
        return (c[7:6] != 2'b00) && (c[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/vsd_hkspi_slave.sv
// Housekeeping SPI slave: pin synchronizers, command/address/data
// FSM, shift registers and the register-file access strobes.
module vsd_hkspi_slave
    import vsd_caravel_pkg::*;
(
    input  logic       clock,
    input  logic       resetb,
    input  logic       sck,
    input  logic       csb,
    input  logic       sdi,
    input  logic [7:0] rdata,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    output logic       wstrobe,
    output logic       pass_active
);

    logic [1:0] sck_q;
    logic [1:0] csb_q;
    logic [1:0] sdi_q;
    logic       sck_d;
    logic       sck_s;
    logic       csb_s;
    logic       sdi_s;
    logic       sck_rise;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic       last_byte;

    hk_state_e  state;
    logic [2:0] bit_cnt;
    logic [6:0] in_sh;
    logic [7:0] out_sh;
    logic [1:0] mode;
    logic       lim_en;
    logic [2:0] rem;
    logic       ld_pend;

    assign sck_s     = sck_q[1];
    assign csb_s     = csb_q[1];
    assign sdi_s     = sdi_q[1];
    assign sck_rise  = sck_s & ~sck_d;
    assign byte_done = sck_rise & (bit_cnt == 3'd7);
    assign rx_byte   = {in_sh, sdi_s};
    assign last_byte = lim_en & (rem == 3'd1);

    // Commit happens on the completing edge, while addr still points here.
    assign wstrobe = byte_done & ~csb_s & (state == ST_DATA) & mode[1];
    assign wdata   = rx_byte;

    assign sdo         = out_sh[7];
    assign sdo_oe      = ~csb_s;
    assign pass_active = (state == ST_PASS);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sck_q   <= 2'b00;
            csb_q   <= 2'b11;
            sdi_q   <= 2'b00;
            sck_d   <= 1'b0;
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            in_sh   <= 7'd0;
            out_sh  <= 8'd0;
            mode    <= 2'b00;
            lim_en  <= 1'b0;
            rem     <= 3'd0;
            addr    <= 8'd0;
            ld_pend <= 1'b0;
        end else begin
            sck_q   <= {sck_q[0], sck};
            csb_q   <= {csb_q[0], csb};
            sdi_q   <= {sdi_q[0], sdi};
            sck_d   <= sck_s;
            ld_pend <= 1'b0;
            if (ld_pend)
                out_sh <= rdata;
            if (csb_s) begin
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state   <= ST_CMD;
                        bit_cnt <= 3'd0;
                    end
                    ST_CMD, ST_ADDR, ST_DATA: begin
                        if (sck_rise) begin
                            in_sh   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            out_sh  <= {out_sh[6:0], 1'b0};
                        end
                        if (byte_done && state == ST_CMD) begin
                            if (rx_byte == CMD_PASSTHRU) begin
                                state <= ST_PASS;
                            end else if (is_stream(rx_byte)) begin
                                mode   <= rx_byte[7:6];
                                lim_en <= (rx_byte[5:3] != 3'd0);
                                rem    <= rx_byte[5:3];
                                state  <= ST_ADDR;
                            end else begin
                                state <= ST_DONE;
                            end
                        end
                        if (byte_done && state == ST_ADDR) begin
                            addr    <= rx_byte;
                            state   <= ST_DATA;
                            ld_pend <= mode[0];
                        end
                        if (byte_done && state == ST_DATA) begin
                            addr <= addr + 8'd1;
                            rem  <= rem - 3'd1;
                            if (last_byte)
                                state <= ST_DONE;
                            else
                                ld_pend <= mode[0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/vsd_caravel_hk.sv
// vsdcaravel chip-top housekeeping: register file, flash
// pass-through muxing and pad hookup around the SPI slave.
module vsd_caravel_hk
    import vsd_caravel_pkg::*;
#(
    parameter logic [11:0] MFGR_ID      = MFGR_ID_DEF,
    parameter logic [7:0]  PROD_ID      = PROD_ID_DEF,
    parameter logic [25:0] PLL_TRIM_RST = PLL_TRIM_DEF
) (
    input  logic        clock,
    input  logic        resetb,
    inout  wire  [37:0] mprj_io,
    inout  wire         gpio,
    output logic        flash_csb,
    output logic        flash_clk,
    inout  wire         flash_io0,
    inout  wire         flash_io1,
    inout  wire         vddio,
    inout  wire         vddio_2,
    inout  wire         vssio,
    inout  wire         vssio_2,
    inout  wire         vdda,
    inout  wire         vssa,
    inout  wire         vccd,
    inout  wire         vssd,
    inout  wire         vdda1,
    inout  wire         vdda1_2,
    inout  wire         vdda2,
    inout  wire         vssa1,
    inout  wire         vssa1_2,
    inout  wire         vssa2,
    inout  wire         vccd1,
    inout  wire         vccd2,
    inout  wire         vssd1,
    inout  wire         vssd2
);

    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        wstrobe;
    logic [7:0]  rdata;
    logic        pass_active;
    logic        sdo;
    logic        sdo_oe;
    logic        core_rstn;
    logic        pass_en;
    logic        unused_pins;

    logic [1:0]  pll_en;
    logic        pll_byp;
    logic        irq;
    logic        ext_rst;
    logic [25:0] trim;
    logic [5:0]  pll_src;
    logic [4:0]  pll_div;

    vsd_hkspi_slave u_spi (
        .clock       (clock),
        .resetb      (resetb),
        .sck         (mprj_io[4]),
        .csb         (mprj_io[3]),
        .sdi         (mprj_io[2]),
        .rdata       (rdata),
        .sdo         (sdo),
        .sdo_oe      (sdo_oe),
        .addr        (addr),
        .wdata       (wdata),
        .wstrobe     (wstrobe),
        .pass_active (pass_active)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            pll_en  <= PLL_EN_RST;
            pll_byp <= PLL_BYP_RST;
            irq     <= 1'b0;
            ext_rst <= 1'b0;
            trim    <= PLL_TRIM_RST;
            pll_src <= PLL_SRC_RST;
            pll_div <= PLL_DIV_RST;
        end else if (wstrobe) begin
            unique case (addr)
                A_PLL_EN:  pll_en        <= wdata[1:0];
                A_PLL_BYP: pll_byp       <= wdata[0];
                A_IRQ:     irq           <= wdata[0];
                A_EXT_RST: ext_rst       <= wdata[0];
                A_TRIM0:   trim[7:0]     <= wdata;
                A_TRIM1:   trim[15:8]    <= wdata;
                A_TRIM2:   trim[23:16]   <= wdata;
                A_TRIM3:   trim[25:24]   <= wdata[1:0];
                A_PLL_SRC: pll_src       <= wdata[5:0];
                A_PLL_DIV: pll_div       <= wdata[4:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        unique case (addr)
            A_STATUS:  rdata = 8'h00;
            A_MFGR_HI: rdata = {4'b0, MFGR_ID[11:8]};
            A_MFGR_LO: rdata = MFGR_ID[7:0];
            A_PROD:    rdata = PROD_ID;
            A_PLL_EN:  rdata = {6'b0, pll_en};
            A_PLL_BYP: rdata = {7'b0, pll_byp};
            A_IRQ:     rdata = {7'b0, irq};
            A_EXT_RST: rdata = {7'b0, ext_rst};
            A_TRIM0:   rdata = trim[7:0];
            A_TRIM1:   rdata = trim[15:8];
            A_TRIM2:   rdata = trim[23:16];
            A_TRIM3:   rdata = {6'b0, trim[25:24]};
            A_PLL_SRC: rdata = {2'b0, pll_src};
            A_PLL_DIV: rdata = {3'b0, pll_div};
            default:   rdata = 8'h00;
        endcase
    end

    // External reset holds the flash side idle but not the SPI slave.
    assign core_rstn = ~ext_rst;
    assign pass_en   = pass_active & core_rstn;

    assign flash_csb  = pass_en ? mprj_io[3] : 1'b1;
    assign flash_clk  = pass_en ? mprj_io[4] : 1'b0;
    assign flash_io0  = pass_en ? mprj_io[2] : 1'bz;
    assign mprj_io[1] = pass_en ? flash_io1 :
                        (sdo_oe ? sdo : 1'bz);

    assign unused_pins = ^{mprj_io[37:5], mprj_io[0], gpio,
                           vddio, vddio_2, vssio, vssio_2,
                           vdda, vssa, vccd, vssd,
                           vdda1, vdda1_2, vdda2, vssa1,
                           vssa1_2, vssa2, vccd1, vccd2,
                           vssd1, vssd2, irq, pll_byp,
                           pll_en, trim, pll_src, pll_div,
                           LAST_REG, CMD_WSTREAM,
                           CMD_RSTREAM, CMD_RWSTREAM};

endmodule

// File: tb/tb_vsd_caravel_hk.sv
// Directed bench for the housekeeping SPI: register
// vectors, stream/limit/rw commands and flash pass-through.
module tb_vsd_caravel_hk;

    localparam int HALF = 8;

    logic clock = 1'b0;
    logic resetb = 1'b0;
    logic sck = 1'b0;
    logic csb = 1'b1;
    logic sdi = 1'b0;
    logic f_io1 = 1'b0;

    wire [37:0] mprj_io;
    wire gpio;
    wire flash_csb;
    wire flash_clk;
    wire flash_io0;
    wire flash_io1;
    wire vddio, vddio_2, vssio, vssio_2, vdda, vssa;
    wire vccd, vssd, vdda1, vdda1_2, vdda2, vssa1;
    wire vssa1_2, vssa2, vccd1, vccd2, vssd1, vssd2;

    assign mprj_io[4] = sck;
    assign mprj_io[3] = csb;
    assign mprj_io[2] = sdi;
    assign flash_io1  = f_io1;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    vsd_caravel_hk dut (
        .clock(clock), .resetb(resetb), .mprj_io(mprj_io),
        .gpio(gpio), .flash_csb(flash_csb),
        .flash_clk(flash_clk), .flash_io0(flash_io0),
        .flash_io1(flash_io1), .vddio(vddio),
        .vddio_2(vddio_2), .vssio(vssio), .vssio_2(vssio_2),
        .vdda(vdda), .vssa(vssa), .vccd(vccd), .vssd(vssd),
        .vdda1(vdda1), .vdda1_2(vdda1_2), .vdda2(vdda2),
        .vssa1(vssa1), .vssa1_2(vssa1_2), .vssa2(vssa2),
        .vccd1(vccd1), .vccd2(vccd2), .vssd1(vssd1),
        .vssd2(vssd2)
    );

    typedef struct {
        logic       wr;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [13];

    logic [7:0] stream_exp [19] = '{
        8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF,
        8'hEF, 8'hFF, 8'h03, 8'h12, 8'h04
    };

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            sdi = tx[i];
            clocks(HALF);
            rx[i] = mprj_io[1];
            sck = 1'b1;
            clocks(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_begin();
        csb = 1'b0;
        clocks(4);
    endtask

    task automatic cs_end();
        clocks(4);
        csb = 1'b1;
        clocks(8);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rx;
        cs_begin();
        spi_byte(8'h80, rx);
        spi_byte(a, rx);
        spi_byte(d, rx);
        cs_end();
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
        logic [7:0] rx;
        cs_begin();
        spi_byte(8'h40, rx);
        spi_byte(a, rx);
        spi_byte(8'h00, d);
        cs_end();
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] pat;

        vt[0]  = '{1'b0, 8'h03, 8'h00, 8'h11};
        vt[1]  = '{1'b1, 8'h12, 8'h1F, 8'h1F};
        vt[2]  = '{1'b1, 8'h03, 8'hAA, 8'h11};
        vt[3]  = '{1'b0, 8'h13, 8'h00, 8'h00};
        vt[4]  = '{1'b1, 8'h08, 8'hFF, 8'h03};
        vt[5]  = '{1'b1, 8'h11, 8'hFF, 8'h3F};
        vt[6]  = '{1'b1, 8'h0D, 8'h5A, 8'h5A};
        vt[7]  = '{1'b1, 8'h10, 8'hFE, 8'h02};
        vt[8]  = '{1'b1, 8'h00, 8'h55, 8'h00};
        vt[9]  = '{1'b1, 8'h0C, 8'hFF, 8'h00};
        vt[10] = '{1'b0, 8'hFF, 8'h00, 8'h00};
        vt[11] = '{1'b1, 8'h09, 8'hFE, 8'h00};
        vt[12] = '{1'b1, 8'h0A, 8'hFF, 8'h01};

        clocks(3);
        check("rst_flash_csb", {7'b0, flash_csb}, 8'h01);
        check("rst_flash_clk", {7'b0, flash_clk}, 8'h00);
        resetb = 1'b1;
        clocks(4);
        check("rst_core_rstn", {7'b0, dut.core_rstn}, 8'h01);

        reg_read(8'h03, rx);
        check("reset_prod_id", rx, 8'h11);

        cs_begin();
        spi_byte(8'h40, rx);
        spi_byte(8'h00, rx);
        for (int i = 0; i < 19; i++) begin
            spi_byte(8'h00, rx);
            check($sformatf("stream%0d", i), rx, stream_exp[i]);
        end
        cs_end();

        for (int i = 0; i < 13; i++) begin
            if (vt[i].wr)
                reg_write(vt[i].a, vt[i].wd);
            reg_read(vt[i].a, rx);
            check($sformatf("vec%0d", i), rx, vt[i].exp);
        end

        reg_write(8'h0B, 8'h01);
        check("ext_rst_core", {7'b0, dut.core_rstn}, 8'h00);
        cs_begin();
        spi_byte(8'hC4, rx);
        clocks(4);
        sck = 1'b1;
        #1;
        check("ext_rst_csb", {7'b0, flash_csb}, 8'h01);
        check("ext_rst_clk", {7'b0, flash_clk}, 8'h00);
        sck = 1'b0;
        cs_end();
        reg_write(8'h0B, 8'h00);
        check("ext_clr_core", {7'b0, dut.core_rstn}, 8'h01);
        reg_read(8'h0B, rx);
        check("ext_clr_read", rx, 8'h00);

        cs_begin();
        spi_byte(8'h80, rx);
        spi_byte(8'h12, rx);
        spi_bits(8'h05, 4, rx);
        cs_end();
        reg_read(8'h12, rx);
        check("partial_nowrite", rx, 8'h1F);
        reg_write(8'h12, 8'h07);
        reg_read(8'h12, rx);
        check("after_partial", rx, 8'h07);

        cs_begin();
        spi_byte(8'h88, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h05, rx);
        spi_byte(8'h06, rx);
        cs_end();
        reg_read(8'h11, rx);
        check("limit_first", rx, 8'h05);
        reg_read(8'h12, rx);
        check("limit_second", rx, 8'h07);

        cs_begin();
        spi_byte(8'hC0, rx);
        spi_byte(8'h0D, rx);
        spi_byte(8'h11, rx);
        cs_end();
        check("rw_old", rx, 8'h5A);
        reg_read(8'h0D, rx);
        check("rw_new", rx, 8'h11);

        cs_begin();
        spi_byte(8'h40, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h00, rx);
        check("wrap_ff", rx, 8'h00);
        spi_byte(8'h00, rx);
        check("wrap_00", rx, 8'h00);
        spi_byte(8'h00, rx);
        check("wrap_01", rx, 8'h04);
        cs_end();

        cs_begin();
        spi_byte(8'hC4, rx);
        clocks(4);
        check("pass_csb", {7'b0, flash_csb}, 8'h00);
        pat = 8'hAB;
        for (int i = 7; i >= 0; i--) begin
            sdi = pat[i];
            f_io1 = ~pat[i];
            clocks(2);
            check($sformatf("pass_io0_%0d", i), {7'b0, flash_io0},
                  {7'b0, pat[i]});
            check($sformatf("pass_sdo_%0d", i), {7'b0, mprj_io[1]},
                  {7'b0, ~pat[i]});
            sck = 1'b1;
            #1;
            check($sformatf("pass_clk_%0d", i), {7'b0, flash_clk}, 8'h01);
            clocks(2);
            sck = 1'b0;
            #1;
            check($sformatf("pass_clkl_%0d", i), {7'b0, flash_clk}, 8'h00);
        end
        csb = 1'b1;
        #1;
        check("pass_end_csb", {7'b0, flash_csb}, 8'h01);
        clocks(8);
        sck = 1'b1;
        #1;
        check("pass_end_clk", {7'b0, flash_clk}, 8'h00);
        sck = 1'b0;
        clocks(4);

        reg_read(8'h02, rx);
        check("after_pass", rx, 8'h56);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
